// File: rtl/f1_pkg.sv
// Shared types, constants and the LFSR step function for the F1 start-light controller.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HOLD = 2'd2,
        GO   = 2'd3
    } f1_ctrl_state_t;

    localparam int NUM_LIGHTS = 8;

    // Feedback taps for x^7+x^6+1: bits 6 and 5 of the shift register.
    localparam logic [15:0] LFSR_TAPS_7 = 16'h0060;

    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            3:       lfsr_taps = 16'h0006;
            4:       lfsr_taps = 16'h000C;
            5:       lfsr_taps = 16'h0014;
            6:       lfsr_taps = 16'h0030;
            8:       lfsr_taps = 16'h00B8;
            default: lfsr_taps = LFSR_TAPS_7;
        endcase
    endfunction

    // Fibonacci step; bits above the register width are forced to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s, input int w);
        logic [15:0] mask;
        logic        fb;
        mask      = (16'h0001 << w) - 16'h0001;
        fb        = ^(s & lfsr_taps(w));
        lfsr_next = {s[14:0], fb} & mask;
    endfunction

endpackage

// File: rtl/f1_start_ctrl_if.sv
// Control/status bundle between the start controller (slave) and its user (master).
interface f1_start_ctrl_if #(
    parameter int REACT_W = 16
);
    import f1_pkg::*;

    // trigger is a fire-and-forget request with no ready: it is acted on only when
    // busy is low and is dropped otherwise; every output pulse lasts exactly one cycle.
    logic               trigger;
    logic               react_btn;
    logic               light_step;
    logic               light_rst;
    logic               busy;
    logic               react_valid;
    logic [REACT_W-1:0] react_time;
    logic               false_start;
    logic [REACT_W-1:0] best_time;
    f1_ctrl_state_t     dbg_state;

    modport master (
        output trigger, react_btn,
        input  light_step, light_rst, busy, react_valid, react_time,
               false_start, best_time, dbg_state
    );

    modport slave (
        input  trigger, react_btn,
        output light_step, light_rst, busy, react_valid, react_time,
               false_start, best_time, dbg_state
    );

endinterface

// File: rtl/f1_tick_div.sv
// Reloadable down-counter giving a one-cycle tick every TICK_DIV cycles while enabled.
module f1_tick_div #(
    parameter int TICK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW     = $clog2(TICK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start sequencer: steps eight lights, holds for a random time, then times the driver.
// Optional best-time tracking is enabled by defining F1_BEST_TIME_EN.
module f1_start_ctrl
    import f1_pkg::*;
#(
    parameter int TICK_DIV = 16,
    parameter int MIN_HOLD = 2,
    parameter int LFSR_W   = 7,
    parameter int REACT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    f1_start_ctrl_if.slave bus
);

    localparam logic [REACT_W-1:0] REACT_MAX = '1;

    f1_ctrl_state_t     r_state;
    f1_ctrl_state_t     w_next;
    logic [15:0]        r_lfsr;
    logic [15:0]        r_hold;
    logic [3:0]         r_step;
    logic [REACT_W-1:0] r_react;
    logic [REACT_W-1:0] r_react_time;
    logic               r_react_valid;
    logic [REACT_W-1:0] w_react_inc;
    logic [REACT_W-1:0] w_best;

    logic w_tick, w_tick_en, w_tick_load;
    logic w_step_clr, w_step_inc, w_hold_load, w_hold_dec, w_react_clr;
    logic w_done, w_timeout, w_light_step, w_light_rst, w_false_start;

    assign w_tick_en   = (r_state == ARM) || (r_state == HOLD);
    assign w_react_inc = (r_react == REACT_MAX) ? REACT_MAX : r_react + 1'b1;

    f1_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tick_load),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // The button is checked before the tick so an early press always beats a strobe.
    always_comb begin
        w_next        = r_state;
        w_tick_load   = 1'b0;
        w_step_clr    = 1'b0;
        w_step_inc    = 1'b0;
        w_hold_load   = 1'b0;
        w_hold_dec    = 1'b0;
        w_react_clr   = 1'b0;
        w_done        = 1'b0;
        w_timeout     = 1'b0;
        w_light_step  = 1'b0;
        w_light_rst   = 1'b0;
        w_false_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.trigger) begin
                    w_next      = ARM;
                    w_tick_load = 1'b1;
                    w_step_clr  = 1'b1;
                end
            end
            ARM: begin
                if (bus.react_btn) begin
                    w_false_start = 1'b1;
                    w_light_rst   = 1'b1;
                    w_next        = IDLE;
                end else if (w_tick) begin
                    w_light_step = 1'b1;
                    w_step_inc   = 1'b1;
                    if (r_step == 4'(NUM_LIGHTS - 1)) begin
                        w_hold_load = 1'b1;
                        w_next      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.react_btn) begin
                    w_false_start = 1'b1;
                    w_light_rst   = 1'b1;
                    w_next        = IDLE;
                end else if (w_tick) begin
                    if (r_hold == 16'd1) begin
                        w_light_step = 1'b1;
                        w_react_clr  = 1'b1;
                        w_next       = GO;
                    end else begin
                        w_hold_dec = 1'b1;
                    end
                end
            end
            GO: begin
                if (bus.react_btn) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else if (r_react == REACT_MAX) begin
                    w_done    = 1'b1;
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The reaction counter runs one behind the cycle count since the final strobe,
    // so the captured time is its incremented value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr        <= 16'd1;
            r_step        <= '0;
            r_hold        <= '0;
            r_react       <= '0;
            r_react_time  <= '0;
            r_react_valid <= 1'b0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr, LFSR_W);
            if (w_step_clr)      r_step <= '0;
            else if (w_step_inc) r_step <= r_step + 1'b1;
            if (w_hold_load)     r_hold <= 16'(MIN_HOLD) + r_lfsr;
            else if (w_hold_dec) r_hold <= r_hold - 1'b1;
            if (w_react_clr)         r_react <= '0;
            else if (r_state == GO)  r_react <= w_react_inc;
            r_react_valid <= w_done;
            if (w_done) r_react_time <= w_timeout ? REACT_MAX : w_react_inc;
        end
    end

`ifdef F1_BEST_TIME_EN
    logic [REACT_W-1:0] r_best;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_best <= REACT_MAX;
        end else if (w_done && !w_timeout && (w_react_inc < r_best)) begin
            r_best <= w_react_inc;
        end
    end

    assign w_best = r_best;
`else
    assign w_best = REACT_MAX;
`endif

    assign bus.light_step  = w_light_step;
    assign bus.light_rst   = w_light_rst;
    assign bus.false_start = w_false_start;
    assign bus.busy        = (r_state != IDLE);
    assign bus.react_valid = r_react_valid;
    assign bus.react_time  = r_react_time;
    assign bus.best_time   = w_best;
    assign bus.dbg_state   = r_state;

endmodule

// File: doc/f1_start_ctrl.md
Name: f1_start_ctrl

Overview:
- Sequencing controller for the F1 start-light FSM, an eight-light counter that advances one light per enable strobe and wraps from all-lit to all-off on the next strobe.
- On a trigger, it steps the lights on at a fixed tick rate, then holds all eight lit for a pseudo-random number of ticks.
- It then issues one extra strobe to put the lights out and measures the driver's reaction time in clock cycles.
- It also detects false starts and resets the light FSM when one occurs.

Parameters:
- TICK_DIV, 16: clock cycles per light tick; minimum 2.
- MIN_HOLD, 2: fixed hold ticks added to the random component.
- LFSR_W, 7: LFSR width; random hold component ranges 1..2^LFSR_W-1.
- REACT_W, 16: reaction counter width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- trigger  in  1  start request, sampled synchronously; a single-cycle pulse is sufficient.
- react_btn  in  1  driver button, synchronous, level.
- light_step  out  1  one-cycle enable strobe to the light FSM.
- light_rst  out  1  one-cycle reset pulse to the light FSM, high active.
- busy  out  1  high in any state other than IDLE.
- react_valid  out  1  one-cycle pulse; react_time is valid in this cycle.
- react_time  out  REACT_W  latched reaction count.
- false_start  out  1  one-cycle pulse on an early button press.
- best_time  out  REACT_W  lowest valid reaction time since reset (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; tick/hold/reaction counters 0.
  - LFSR = 1.
  - All strobes and pulses 0; react_time 0; best_time all-ones.
- LFSR:
  - Fibonacci, polynomial x^7+x^6+1 for LFSR_W=7.
  - Free-runs every cycle, never 0.
  - Provides a function lfsr_next.
- States: IDLE, ARM, HOLD, GO.
- IDLE:
  - trigger=1 -> ARM; tick counter loads TICK_DIV-1; step count cleared.
  - react_btn in IDLE is ignored, including when it coincides with trigger (trigger wins).
- ARM:
  - Tick counter decrements each cycle.
  - At 0: light_step=1 for one cycle, counter reloads, step count increments.
  - Strobes land TICK_DIV, 2*TICK_DIV, ... 8*TICK_DIV cycles after the trigger cycle.
  - After the 8th strobe -> HOLD. Hold count loads MIN_HOLD + LFSR value from the same cycle; tick counter reloads.
- HOLD:
  - Hold count decrements once per tick.
  - When the hold count reaches 0 at a tick: light_step=1 (9th strobe, lights wrap to off); reaction counter cleared to 0; -> GO.
- GO:
  - Reaction counter increments every cycle and saturates at all-ones.
  - react_btn=1: react_time <= counter value; react_valid=1; -> IDLE.
  - Counter saturates with no press (timeout): react_time <= all-ones; react_valid=1; -> IDLE.
- False start:
  - react_btn=1 in ARM or HOLD -> false_start=1, light_rst=1, no light_step, -> IDLE.
  - The button also wins when it coincides with an ARM strobe or with the final HOLD tick.
- trigger outside IDLE: ignored; no queuing.
- light_step and light_rst are never high in the same cycle.
- Reset mid-sequence: immediate return to IDLE with all outputs at reset values. The light FSM shares rst, so it also clears.

Optional Feature:
- Macro F1_BEST_TIME_EN.
- Defined:
  - On each react_valid that is not a timeout, best_time <= min(best_time, react_time).
  - False starts and timeouts never update best_time.
- Undefined: best_time is held at all-ones and no comparator is synthesised.

Decomposition:
- Package f1_pkg holds:
  - enum f1_ctrl_state_t {IDLE, ARM, HOLD, GO};
  - NUM_LIGHTS=8;
  - LFSR tap constant;
  - lfsr_next function.
- One sub-module, f1_tick_div, containing the reloadable down-counter that produces a tick pulse every TICK_DIV cycles while enabled.
- LFSR and FSM stay in the top module.

Test Plan (TICK_DIV=4, MIN_HOLD=2, LFSR_W=7, REACT_W=16):
- Reset release, trigger at cycle T:
  - light_step at T+4, T+8, ..., T+32.
  - busy high from T+1.
  - Bench model predicts LFSR value L at the 8th strobe; 9th strobe at T+32+4*(2+L).
- react_btn asserted 37 cycles after the 9th strobe -> react_valid for 1 cycle with react_time=37; busy low the next cycle.
- react_btn high 2 cycles after the 3rd strobe:
  - false_start=1 and light_rst=1 in that cycle only.
  - No further light_step; react_valid never asserts.
- No press after the 9th strobe -> react_valid at counter saturation with react_time=16'hFFFF; best_time unchanged.
- Second trigger during HOLD -> ignored; strobe timing identical to the single-trigger case.
- With F1_BEST_TIME_EN, valid runs of 50 then 30 then 40:
  - best_time reads 50, then 30, then 30.
  - rst low mid-ARM returns best_time to 16'hFFFF and all outputs to 0.
